// File: rtl/reservation_station_param_if.sv
// ---------------------------------------------------------------------------
// reservation_station_param_if
//   Bundles the three handshakes of the reservation station:
//     dispatch : disp_valid/disp_ready + op, dest tag, source tags/values
//     CDB      : cdb_valid + broadcast tag/data (no back-pressure)
//     issue    : iss_valid/iss_ready + op, dest tag, operand values
//     count    : number of busy station slots (issue register excluded)
//   master : the surrounding pipeline (rename stage, CDB, functional unit)
//   slave  : the reservation station itself
// ---------------------------------------------------------------------------
interface reservation_station_param_if #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int OPC_W   = 16
);
  localparam int CNT_W = $clog2(ENTRIES + 1);

  logic              disp_valid;
  logic              disp_ready;
  logic [OPC_W-1:0]  disp_op;
  logic [TAG_W-1:0]  disp_tag;
  logic [TAG_W-1:0]  disp_qj;
  logic [TAG_W-1:0]  disp_qk;
  logic [DATA_W-1:0] disp_vj;
  logic [DATA_W-1:0] disp_vk;

  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;

  logic              iss_valid;
  logic              iss_ready;
  logic [OPC_W-1:0]  iss_op;
  logic [TAG_W-1:0]  iss_tag;
  logic [DATA_W-1:0] iss_vj;
  logic [DATA_W-1:0] iss_vk;

  logic [CNT_W-1:0]  count;

  modport master (
    output disp_valid, disp_op, disp_tag, disp_qj, disp_qk, disp_vj, disp_vk,
    input  disp_ready,
    output cdb_valid, cdb_tag, cdb_data,
    input  iss_valid, iss_op, iss_tag, iss_vj, iss_vk,
    output iss_ready,
    input  count
  );

  modport slave (
    input  disp_valid, disp_op, disp_tag, disp_qj, disp_qk, disp_vj, disp_vk,
    output disp_ready,
    input  cdb_valid, cdb_tag, cdb_data,
    output iss_valid, iss_op, iss_tag, iss_vj, iss_vk,
    input  iss_ready,
    output count
  );
endinterface

// File: rtl/reservation_station_param.sv
// ---------------------------------------------------------------------------
// reservation_station_param
//   Tomasulo reservation station with ENTRIES slots. Renamed instructions are
//   dispatched into the lowest free slot, waiting operands are woken by CDB
//   broadcasts (tag 0 means "value present"), and the oldest fully ready slot
//   is moved into a registered issue stage drained by a valid/ready handshake.
// Ports
//   clk_i   : rising-edge clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous clear of all slots and the issue register
//   rs_if   : dispatch / CDB / issue / count bundle (slave side)
// ---------------------------------------------------------------------------
module reservation_station_param #(
  parameter int ENTRIES = 8,
  parameter int DATA_W  = 16,
  parameter int TAG_W   = 3,
  parameter int OPC_W   = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          flush_i,
  reservation_station_param_if.slave    rs_if
);

  localparam int CNT_W  = $clog2(ENTRIES + 1);
  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int RANK_W = IDX_W;

  // Slot state
  logic [ENTRIES-1:0] busy_q;
  logic [OPC_W-1:0]   op_q   [ENTRIES];
  logic [TAG_W-1:0]   tag_q  [ENTRIES];
  logic [TAG_W-1:0]   qj_q   [ENTRIES];
  logic [TAG_W-1:0]   qk_q   [ENTRIES];
  logic [DATA_W-1:0]  vj_q   [ENTRIES];
  logic [DATA_W-1:0]  vk_q   [ENTRIES];
  logic [RANK_W-1:0]  rank_q [ENTRIES];

  // Issue register and occupancy
  logic               iss_valid_q;
  logic [OPC_W-1:0]   iss_op_q;
  logic [TAG_W-1:0]   iss_tag_q;
  logic [DATA_W-1:0]  iss_vj_q;
  logic [DATA_W-1:0]  iss_vk_q;
  logic [CNT_W-1:0]   count_q, count_d;

  // Per-slot combinational status
  logic [ENTRIES-1:0] slot_rdy;
  logic [ENTRIES-1:0] hit_j;
  logic [ENTRIES-1:0] hit_k;

  logic               cdb_live;
  assign cdb_live = rs_if.cdb_valid && (rs_if.cdb_tag != '0);

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_slot_stat
      // Readiness uses pre-edge tags, so a wakeup only counts next cycle.
      assign slot_rdy[gi] = busy_q[gi] && (qj_q[gi] == '0) && (qk_q[gi] == '0);
      assign hit_j[gi]    = busy_q[gi] && cdb_live && (qj_q[gi] == rs_if.cdb_tag);
      assign hit_k[gi]    = busy_q[gi] && cdb_live && (qk_q[gi] == rs_if.cdb_tag);
    end
  endgenerate

  // Oldest ready slot: smallest rank among ready slots (ranks are unique).
  logic              sel_found;
  logic [IDX_W-1:0]  sel_idx;
  logic [RANK_W-1:0] sel_rank;

  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_rank  = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (slot_rdy[i] && (!sel_found || (rank_q[i] < sel_rank))) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
        sel_rank  = rank_q[i];
      end
    end
  end

  // Lowest-index free slot (scan downward so the lowest index wins).
  logic             free_found;
  logic [IDX_W-1:0] free_idx;

  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
  end

  logic disp_acc;
  logic load_iss;

  assign disp_acc = rs_if.disp_valid && free_found && !flush_i;
  assign load_iss = (!iss_valid_q || rs_if.iss_ready) && !flush_i && sel_found;

  // Dispatch-side CDB bypass: a source produced this very cycle is captured now.
  logic              byp_j, byp_k;
  logic [TAG_W-1:0]  disp_qj_eff, disp_qk_eff;
  logic [DATA_W-1:0] disp_vj_eff, disp_vk_eff;

  assign byp_j       = cdb_live && (rs_if.disp_qj == rs_if.cdb_tag);
  assign byp_k       = cdb_live && (rs_if.disp_qk == rs_if.cdb_tag);
  assign disp_qj_eff = byp_j ? '0 : rs_if.disp_qj;
  assign disp_qk_eff = byp_k ? '0 : rs_if.disp_qk;
  assign disp_vj_eff = byp_j ? rs_if.cdb_data : rs_if.disp_vj;
  assign disp_vk_eff = byp_k ? rs_if.cdb_data : rs_if.disp_vk;

  // If a slot leaves on the same edge, everyone above it shifts down by one,
  // so the newcomer takes the rank just past the surviving entries.
  logic [CNT_W-1:0]  new_rank_full;
  logic [RANK_W-1:0] new_rank;

  assign new_rank_full = count_q - CNT_W'(load_iss);
  assign new_rank      = RANK_W'(new_rank_full);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        op_q[i]   <= '0;
        tag_q[i]  <= '0;
        qj_q[i]   <= '0;
        qk_q[i]   <= '0;
        vj_q[i]   <= '0;
        vk_q[i]   <= '0;
        rank_q[i] <= '0;
      end
    end else if (flush_i) begin
      busy_q <= '0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (disp_acc && (free_idx == IDX_W'(i))) begin
          busy_q[i] <= 1'b1;
          op_q[i]   <= rs_if.disp_op;
          tag_q[i]  <= rs_if.disp_tag;
          qj_q[i]   <= disp_qj_eff;
          qk_q[i]   <= disp_qk_eff;
          vj_q[i]   <= disp_vj_eff;
          vk_q[i]   <= disp_vk_eff;
          rank_q[i] <= new_rank;
        end else begin
          if (load_iss && (sel_idx == IDX_W'(i))) begin
            busy_q[i] <= 1'b0;
          end
          if (hit_j[i]) begin
            qj_q[i] <= '0;
            vj_q[i] <= rs_if.cdb_data;
          end
          if (hit_k[i]) begin
            qk_q[i] <= '0;
            vk_q[i] <= rs_if.cdb_data;
          end
          if (load_iss && busy_q[i] && (rank_q[i] > sel_rank)) begin
            rank_q[i] <= rank_q[i] - RANK_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    count_d = count_q;
    if (flush_i) begin
      count_d = '0;
    end else begin
      case ({disp_acc, load_iss})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      iss_valid_q <= 1'b0;
      iss_op_q    <= '0;
      iss_tag_q   <= '0;
      iss_vj_q    <= '0;
      iss_vk_q    <= '0;
      count_q     <= '0;
    end else begin
      count_q <= count_d;
      if (flush_i) begin
        iss_valid_q <= 1'b0;
      end else if (load_iss) begin
        iss_valid_q <= 1'b1;
        iss_op_q    <= op_q[sel_idx];
        iss_tag_q   <= tag_q[sel_idx];
        iss_vj_q    <= vj_q[sel_idx];
        iss_vk_q    <= vk_q[sel_idx];
      end else if (rs_if.iss_ready) begin
        iss_valid_q <= 1'b0;
      end
    end
  end

  assign rs_if.disp_ready = free_found;
  assign rs_if.iss_valid  = iss_valid_q;
  assign rs_if.iss_op     = iss_op_q;
  assign rs_if.iss_tag    = iss_tag_q;
  assign rs_if.iss_vj     = iss_vj_q;
  assign rs_if.iss_vk     = iss_vk_q;
  assign rs_if.count      = count_q;

endmodule
